lock_reg_access_ctrl: RTL and testbench

Upstream write-access controller for a bank of lockable configuration registers. It accepts bus write requests over a valid/ready handshake and decides whether each write may reach the target register. It drives one-cycle write and lock strobes into the register stage, keeps one sticky lock bit per register, and counts rejected write attempts. Scan mode can never bypass a lock; only debug-unlocked mode can.

---
 rtl/lock_reg_access_ctrl.sv | 130 +++++++++++++
 tb/tb_lock_reg_access_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lock_reg_access_ctrl.sv
// Write-access controller for a bank of lockable configuration registers.
// Each accepted request is checked against its sticky lock bit, then either committed or rejected.
module lock_reg_access_ctrl #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_W     = 2,
  parameter int VIOL_CNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  req_lock,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  input  logic                  scan_mode,
  input  logic                  debug_unlocked,
  output logic [NUM_REGS-1:0]   reg_wr_en,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic [NUM_REGS-1:0]   reg_lock,
  output logic [NUM_REGS-1:0]   lock_status,
  output logic [VIOL_CNT_W-1:0] viol_count
);

  typedef enum logic [2:0] {IDLE, CHECK, COMMIT, REJECT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       hold_addr;
  logic [DATA_W-1:0]       hold_data;
  logic                    hold_lock;
  logic                    err_q, err_nxt;
  logic                    viol_q, viol_nxt;
  logic [NUM_REGS-1:0]     sel;
  logic [NUM_REGS-1:0]     lock_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [VIOL_CNT_W-1:0]   viol_cnt_q;
  logic                    in_range;
  logic                    hit_locked;
  logic                    override;

  // Explicit one-hot decode keeps out-of-range addresses from indexing past the bank.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sel[i] = (hold_addr == ADDR_W'(i));
    end
  end

  assign in_range   = 32'(hold_addr) < 32'(NUM_REGS);
  assign hit_locked = |(lock_q & sel);
  assign override   = debug_unlocked & ~scan_mode;

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    viol_nxt  = viol_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    reg_wr_en = '0;
    reg_lock  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = CHECK;
      end
      CHECK: begin
        if (!in_range) begin
          state_nxt = REJECT;
          err_nxt   = 1'b1;
          viol_nxt  = 1'b0;
        end else if (!hit_locked || override) begin
          state_nxt = COMMIT;
          err_nxt   = 1'b0;
          viol_nxt  = 1'b0;
        end else begin
          state_nxt = REJECT;
          err_nxt   = 1'b1;
          viol_nxt  = 1'b1;
        end
      end
      COMMIT: begin
        reg_wr_en = sel;
        if (hold_lock) reg_lock = sel;
        state_nxt = RESP;
      end
      REJECT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_lock  <= 1'b0;
      err_q      <= 1'b0;
      viol_q     <= 1'b0;
      lock_q     <= '0;
      wdata_q    <= '0;
      viol_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      err_q  <= err_nxt;
      viol_q <= viol_nxt;
      if (state == IDLE && req_valid) begin
        hold_addr <= req_addr;
        hold_data <= req_wdata;
        hold_lock <= req_lock;
      end
      // Data is presented during COMMIT and then held until the next commit.
      if (state == CHECK && state_nxt == COMMIT) wdata_q <= hold_data;
      if (state == COMMIT && hold_lock) lock_q <= lock_q | sel;
      if (state == REJECT && viol_q && viol_cnt_q != '1) viol_cnt_q <= viol_cnt_q + 1'b1;
    end
  end

  assign reg_wdata   = wdata_q;
  assign lock_status = lock_q;
  assign viol_count  = viol_cnt_q;

endmodule

// File: tb/tb_lock_reg_access_ctrl.sv
// Randomized bench for lock_reg_access_ctrl with a transaction-level reference model.
// Uses a 3-register bank on a 2-bit address so the out-of-range path is reachable.
module tb_lock_reg_access_ctrl;

  localparam int DW    = 16;
  localparam int NREGS = 3;
  localparam int AW    = 2;
  localparam int VW    = 8;
  localparam int VMAX  = (1 << VW) - 1;

  logic             Clk = 1'b0;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic             req_lock;
  logic             rsp_valid;
  logic             rsp_err;
  logic             scan_mode;
  logic             debug_unlocked;
  logic [NREGS-1:0] reg_wr_en;
  logic [DW-1:0]    reg_wdata;
  logic [NREGS-1:0] reg_lock;
  logic [NREGS-1:0] lock_status;
  logic [VW-1:0]    viol_count;

  lock_reg_access_ctrl #(
    .DATA_W(DW), .NUM_REGS(NREGS), .ADDR_W(AW), .VIOL_CNT_W(VW)
  ) dut (
    .Clk(Clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .scan_mode(scan_mode), .debug_unlocked(debug_unlocked),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_lock(reg_lock),
    .lock_status(lock_status), .viol_count(viol_count)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: lock bit per register, violation total, last committed data.
  logic [NREGS-1:0] m_lock;
  int               m_viol;
  logic [DW-1:0]    m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock  = '0;
    m_viol  = 0;
    m_wdata = '0;
  endtask

  // One full transaction from the IDLE cycle through RESP, checked each cycle.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk,
                          input bit sc, input bit dbg, input bit hold);
    bit               oor, is_locked, viol, commit;
    logic [NREGS-1:0] exp_we, exp_lk;
    @(negedge Clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_lock = lk;
    scan_mode = sc; debug_unlocked = dbg;
    oor       = (int'(a) >= NREGS);
    is_locked = !oor && (((m_lock >> a) & 1) != 0);
    viol      = is_locked && !(dbg && !sc);
    commit    = !oor && !viol;
    exp_we    = commit ? (NREGS'(1) << a) : '0;
    exp_lk    = (commit && lk) ? (NREGS'(1) << a) : '0;

    @(negedge Clk);
    check("ready_busy", req_ready, 0);
    check("check_wr_en", reg_wr_en, 0);
    check("check_rsp", rsp_valid, 0);
    if (hold) begin
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      req_lock  = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end

    @(negedge Clk);
    scan_mode      = 1'($urandom);
    debug_unlocked = 1'($urandom);
    check("wr_en", reg_wr_en, exp_we);
    check("lock_strobe", reg_lock, exp_lk);
    check("commit_rsp", rsp_valid, 0);
    check("wdata", reg_wdata, commit ? d : m_wdata);
    check("lock_before", lock_status, m_lock);
    if (commit) begin
      m_wdata = d;
      if (lk) m_lock = m_lock | exp_lk;
    end
    if (viol && m_viol < VMAX) m_viol++;

    @(negedge Clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, !commit);
    check("resp_wr_en", reg_wr_en, 0);
    check("lock_status", lock_status, m_lock);
    check("viol_count", viol_count, m_viol);
    check("wdata_hold", reg_wdata, m_wdata);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_lock = 1'b0;
    scan_mode = 1'b0; debug_unlocked = 1'b0;
    model_reset();
    #3;
    check("rst_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_err}, 0);
    check("rst_strobes", {reg_wr_en, reg_lock}, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_lock", lock_status, 0);
    check("rst_viol", viol_count, 0);
    @(negedge Clk);
    resetn = 1'b1;

    do_write(2'd1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(2'd2, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lock_set", lock_status, 3'b100);
    do_write(2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check("viol_one", viol_count, 1);
    do_write(2'd2, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0);
    check("scan_no_bypass", viol_count, 2);
    do_write(2'd2, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    check("debug_override", reg_wdata, 16'hBEEF);
    do_write(2'd3, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
    check("oor_no_viol", viol_count, 2);

    // Reset while committing a locking write to register 0.
    @(negedge Clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = 2'd0; req_wdata = 16'hCAFE; req_lock = 1'b1;
    scan_mode = 1'b0; debug_unlocked = 1'b0;
    @(negedge Clk);
    req_valid = 1'b0;
    @(negedge Clk);
    check("mid_wr_en", reg_wr_en, 3'b001);
    check("mid_lock_strobe", reg_lock, 3'b001);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_ready", req_ready, 1);
    check("async_strobes", {reg_wr_en, reg_lock}, 0);
    check("async_rsp", {rsp_valid, rsp_err}, 0);
    check("async_wdata", reg_wdata, 0);
    check("async_lock", lock_status, 0);
    check("async_viol", viol_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    resetn = 1'b1;
    @(negedge Clk);
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_lock", lock_status, 0);
    do_write(2'd2, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      do_write(AW'($urandom_range(0, 3)), DW'($urandom), ($urandom_range(0, 7) == 0),
               1'($urandom), 1'($urandom), 1'($urandom));
    end

    do_write(2'd0, 16'h00AA, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 260; n++) begin
      do_write(2'd0, DW'($urandom), 1'($urandom), 1'b0, 1'b0, 1'($urandom));
    end
    check("viol_saturated", viol_count, VMAX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
